// File: rtl/param_alu.sv
// Parametrised ALU: single-cycle logic/arithmetic ops plus MUL/MAC through a
// fixed-latency multiply path, with a one-cycle done pulse and held result.
module param_alu #(
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 done,
    output logic                 busy,
    output logic                 err,
    output logic [2*WIDTH-1:0]   result
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_MUL = 3'b100,
        OP_SUB = 3'b101,
        OP_MAC = 3'b110,
        OP_CLR = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_MULT
    } state_e;

    state_e          state;
    op_e             op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [RW-1:0]   acc;
    logic [RW-1:0]   prod_q;
    logic [CW-1:0]   cnt;
    logic            sc_pend;

    logic [RW-1:0]   a_ext;
    logic [RW-1:0]   b_ext;
    logic [RW-1:0]   sc_res;
    logic [RW-1:0]   mac_sum;
    logic            accept;
    logic            is_multi;

    assign a_ext    = {{WIDTH{1'b0}}, a_q};
    assign b_ext    = {{WIDTH{1'b0}}, b_q};
    assign mac_sum  = acc + prod_q;
    assign accept   = start && !busy;
    assign is_multi = (op == OP_MUL) || (op == OP_MAC);

    // Result of the single-cycle op latched on the previous edge.
    always_comb begin
        sc_res = result;
        unique case (op_q)
            OP_ADD:  sc_res = a_ext + b_ext;
            OP_AND:  sc_res = a_ext & b_ext;
            OP_XOR:  sc_res = a_ext ^ b_ext;
            OP_SUB:  sc_res = a_ext - b_ext;
            OP_CLR:  sc_res = '0;
            default: sc_res = result;
        endcase
    end

    // NOTE: every register, including the operand latches, is cleared by reset
    // so that an op discarded mid-flight leaves no trace behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            op_q    <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            prod_q  <= '0;
            cnt     <= '0;
            sc_pend <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
            result  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; the pending single-cycle
            // op reads the old op_q even when a new command overwrites it here.
            done    <= 1'b0;
            err     <= start && busy;
            sc_pend <= 1'b0;

            if (sc_pend) begin
                done   <= 1'b1;
                result <= sc_res;
                if (op_q == OP_CLR) acc <= '0;
            end

            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= op_e'(op);
                        a_q  <= A;
                        b_q  <= B;
                        if (is_multi) begin
                            state <= S_MULT;
                            busy  <= 1'b1;
                            cnt   <= CW'(MUL_LAT - 1);
                        end else begin
                            sc_pend <= 1'b1;
                        end
                    end
                end
                S_MULT: begin
                    // MUL_LAT >= 2 guarantees prod_q is loaded before completion.
                    prod_q <= a_ext * b_ext;
                    if (cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (op_q == OP_MAC) begin
                            acc    <= mac_sum;
                            result <= mac_sum;
                        end else begin
                            result <= prod_q;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_alu.sv
// Scoreboard bench for param_alu (WIDTH=8, MUL_LAT=3): directed commands push
// expected results; a monitor pops and compares on every done pulse.
module tb_param_alu;

    localparam int WIDTH   = 8;
    localparam int MUL_LAT = 3;

    localparam logic [2:0] NOP = 3'b000, ADD = 3'b001, AND_ = 3'b010, XOR_ = 3'b011,
                           MUL = 3'b100, SUB = 3'b101, MAC = 3'b110, CLR = 3'b111;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [2:0]         op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               done;
    logic               busy;
    logic               err;
    logic [2*WIDTH-1:0] result;

    logic [2*WIDTH-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    param_alu #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
        .done(done), .busy(busy), .err(err), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done must match the oldest expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got result %h, expected no completion at %0t",
                             result, $time);
                end else begin
                    check("done_result", 32'(result), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge where the next command may be set.
    task automatic issue(input logic [2:0] c_op, input logic [7:0] c_a, input logic [7:0] c_b,
                         input logic [15:0] c_exp);
        start = 1'b1;
        op    = c_op;
        a     = c_a;
        b     = c_b;
        exp_q.push_back(c_exp);
        @(negedge clk);
        start = 1'b0;
        if (c_op == MUL || c_op == MAC) repeat (MUL_LAT) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = NOP;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset_result", 32'(result), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back single-cycle ops.
        issue(ADD,  8'hFF, 8'h01, 16'h0100);
        issue(SUB,  8'h01, 8'h02, 16'hFFFF);
        issue(XOR_, 8'hAA, 8'hFF, 16'h0055);
        issue(AND_, 8'hF0, 8'h3C, 16'h0030);
        check("sc_busy_low", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);

        // MUL latency plus a rejected ADD at edge N+1.
        start = 1'b1; op = MUL; a = 8'hFF; b = 8'hFF;
        exp_q.push_back(16'hFE01);
        @(negedge clk);                              // after edge N
        check("mul_busy_n", 32'(busy), 32'h1);
        op = ADD; a = 8'h01; b = 8'h01;              // start stays high: rejected at N+1
        @(negedge clk);
        start = 1'b0;
        check("rej_err", 32'(err), 32'h1);
        check("mul_busy_n1", 32'(busy), 32'h1);
        @(negedge clk);                              // after edge N+2
        check("mul_busy_n2", 32'(busy), 32'h1);
        check("mul_done_early", 32'(done), 32'h0);
        check("err_one_cycle", 32'(err), 32'h0);
        @(negedge clk);                              // after edge N+3
        check("mul_busy_fall", 32'(busy), 32'h0);
        check("mul_done_n3", 32'(done), 32'h1);
        repeat (3) @(negedge clk);

        // Start sampled at N+MUL_LAT is rejected; next one is accepted.
        issue(MUL, 8'h02, 8'h03, 16'h0006);
        // issue returned at the negedge after N+MUL_LAT; starting there is legal.
        issue(ADD, 8'h02, 8'h02, 16'h0004);
        repeat (2) @(negedge clk);

        // MAC / CLR sequence with wrap.
        issue(CLR, 8'h00, 8'h00, 16'h0000);
        issue(MAC, 8'h10, 8'h10, 16'h0100);
        issue(MAC, 8'h10, 8'h10, 16'h0200);
        issue(MAC, 8'hFF, 8'hFF, 16'h0001);
        issue(MAC, 8'hFF, 8'hFF, 16'hFE02);
        issue(CLR, 8'h00, 8'h00, 16'h0000);
        issue(MAC, 8'h02, 8'h03, 16'h0006);
        @(negedge clk);

        // NOP holds the previous result.
        issue(ADD, 8'hFF, 8'h01, 16'h0100);
        issue(NOP, 8'h12, 8'h34, 16'h0100);
        repeat (2) @(negedge clk);
        check("nop_hold", 32'(result), 32'h0100);

        // Reset mid-MUL: no completion, state cleared, acc cleared.
        start = 1'b1; op = MUL; a = 8'h0F; b = 8'h0F;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_result", 32'(result), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        repeat (MUL_LAT + 2) @(negedge clk);
        check("rst_no_done", 32'(done), 32'h0);
        issue(MAC, 8'h01, 8'h01, 16'h0001);
        repeat (2) @(negedge clk);

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
